// File: rtl/fifo_stream_pkt_pkg.sv
// Shared definitions for the streaming FIFO: default sizing, packet FSM states
// and a sizing helper used to derive the full-occupancy constant.
package fifo_stream_pkt_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_DISCARD = 2'd2
  } pkt_state_e;

  // Number of RAM words for a given address width.
  function automatic logic [31:0] depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_stream_pkt_oreg.sv
// FWFT output register: holds one word and presents it to the consumer.
// Latency: loads the word at the read pointer on the edge after it becomes readable.
// Backpressure: refills in the same cycle the held word is consumed; holds while ready_i is low.
module fifo_stream_pkt_oreg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  avail_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  load_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  // Load when a word is readable and the register is empty or being drained.
  always_comb begin
    load_o  = avail_i && (!valid_q || ready_i);
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset and flush both empty it.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fifo_stream_pkt.sv
// Stream FIFO with FWFT output, runtime almost-full/empty thresholds and optional packet commit/rollback.
// Latency: a beat (word mode) or commit (packet mode) at edge k shows on o_m_valid after edge k+1.
// Backpressure: o_s_ready drops on registered full (high while discarding an oversize packet); i_m_ready stalls output.
module fifo_stream_pkt
  import fifo_stream_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned PKT_MODE   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  input  logic                  i_s_drop,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  input  logic [ADDR_WIDTH:0]   i_afull_thresh,
  input  logic [ADDR_WIDTH:0]   i_aempty_thresh,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic                  o_pkt_ovf,
  input  logic                  i_clr_err
);

  localparam int unsigned   PW        = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FILL_FULL = PW'(depth_of(ADDR_WIDTH));
  localparam bit            PKT       = (PKT_MODE != 0);

  logic [DATA_WIDTH:0] mem_q [2**ADDR_WIDTH];
  logic [PW-1:0]       wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
  pkt_state_e          state_q, state_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       fill;
  logic                full, s_acc, mem_we, readable, oreg_load;
  logic [DATA_WIDTH:0] rd_word;

  assign fill      = wptr_q - rptr_q;
  assign full      = (fill == FILL_FULL);
  assign o_s_ready = i_rstn && ((state_q == ST_DISCARD) || !full);
  assign s_acc     = i_s_valid && o_s_ready;
  assign readable  = (rptr_q != cptr_q);
  assign rd_word   = mem_q[rptr_q[ADDR_WIDTH-1:0]];
  assign rptr_d    = oreg_load ? rptr_q + 1'b1 : rptr_q;

  // Write/commit pointer updates, packet FSM transitions and the sticky overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    state_d = state_q;
    ovf_d   = ovf_q & ~i_clr_err;
    mem_we  = 1'b0;
    if (!PKT) begin
      if (s_acc) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
      end
      cptr_d = wptr_d;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCEPT: begin
          if (i_s_drop) begin
            // Rollback wins over a beat arriving in the same cycle.
            wptr_d  = cptr_q;
            state_d = ST_IDLE;
          end else if (state_q == ST_ACCEPT && full && cptr_q == rptr_q) begin
            // Whole RAM holds one open packet: it can never commit, so discard it.
            wptr_d  = cptr_q;
            ovf_d   = 1'b1;
            state_d = ST_DISCARD;
          end else if (s_acc) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (i_s_last) begin
              cptr_d  = wptr_q + 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_ACCEPT;
            end
          end
        end
        ST_DISCARD: begin
          if (s_acc && i_s_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Packet FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) state_q <= ST_IDLE;
    else                    state_q <= state_d;
  end

  // Pointer and error registers; reset and flush override same-cycle traffic.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      wptr_q <= '0;
      cptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      cptr_q <= cptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // RAM write port, left unreset so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we && i_rstn && !i_flush)
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= {(PKT ? i_s_last : 1'b0), i_s_data};
  end

  fifo_stream_pkt_oreg #(.DATA_WIDTH(DATA_WIDTH)) u_oreg (
    .clk_i   (i_clk),
    .rstn_i  (i_rstn),
    .flush_i (i_flush),
    .avail_i (readable),
    .data_i  (rd_word[DATA_WIDTH-1:0]),
    .last_i  (rd_word[DATA_WIDTH]),
    .ready_i (i_m_ready),
    .load_o  (oreg_load),
    .valid_o (o_m_valid),
    .data_o  (o_m_data),
    .last_o  (o_m_last)
  );

  assign o_fill        = fill;
  assign o_full        = full;
  assign o_empty       = (fill == '0);
  assign o_almostfull  = (fill >= i_afull_thresh);
  assign o_almostempty = (fill <= i_aempty_thresh);
  assign o_pkt_ovf     = ovf_q;

endmodule

// File: tb/tb_fifo_stream_pkt.sv
// Bench for fifo_stream_pkt: a 512-deep word-mode instance and an 8-deep packet-mode instance,
// each driven by scenario tasks with queue-based expected output.
module tb_fifo_stream_pkt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int n_checks = 0;
  int n_pass   = 0;

  // Word-mode instance, DEPTH 512
  logic       w_flush, w_s_valid, w_s_ready, w_s_last, w_s_drop;
  logic       w_m_valid, w_m_ready, w_m_last, w_clr;
  logic       w_full, w_empty, w_afull, w_aempty, w_ovf;
  logic [7:0] w_s_data, w_m_data;
  logic [9:0] w_afth, w_aeth, w_fill;

  // Packet-mode instance, DEPTH 8
  logic       p_flush, p_s_valid, p_s_ready, p_s_last, p_s_drop;
  logic       p_m_valid, p_m_ready, p_m_last, p_clr;
  logic       p_full, p_empty, p_afull, p_aempty, p_ovf;
  logic [7:0] p_s_data, p_m_data;
  logic [3:0] p_afth, p_aeth, p_fill;

  fifo_stream_pkt #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .PKT_MODE(0)) dut_w (
    .i_clk(clk), .i_rstn(rstn), .i_flush(w_flush),
    .i_s_valid(w_s_valid), .o_s_ready(w_s_ready), .i_s_data(w_s_data),
    .i_s_last(w_s_last), .i_s_drop(w_s_drop),
    .o_m_valid(w_m_valid), .i_m_ready(w_m_ready), .o_m_data(w_m_data), .o_m_last(w_m_last),
    .i_afull_thresh(w_afth), .i_aempty_thresh(w_aeth), .o_fill(w_fill),
    .o_full(w_full), .o_empty(w_empty), .o_almostfull(w_afull), .o_almostempty(w_aempty),
    .o_pkt_ovf(w_ovf), .i_clr_err(w_clr)
  );

  fifo_stream_pkt #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .PKT_MODE(1)) dut_p (
    .i_clk(clk), .i_rstn(rstn), .i_flush(p_flush),
    .i_s_valid(p_s_valid), .o_s_ready(p_s_ready), .i_s_data(p_s_data),
    .i_s_last(p_s_last), .i_s_drop(p_s_drop),
    .o_m_valid(p_m_valid), .i_m_ready(p_m_ready), .o_m_data(p_m_data), .o_m_last(p_m_last),
    .i_afull_thresh(p_afth), .i_aempty_thresh(p_aeth), .o_fill(p_fill),
    .o_full(p_full), .o_empty(p_empty), .o_almostfull(p_afull), .o_almostempty(p_aempty),
    .o_pkt_ovf(p_ovf), .i_clr_err(p_clr)
  );

  // Advance one cycle; inputs are driven and outputs observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    n_checks++; if (w_s_ready !== 1'b0) $display("FAIL reset_s_ready got %b want 0", w_s_ready); else n_pass++;
    n_checks++; if (w_m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", w_m_valid); else n_pass++;
    n_checks++; if (w_fill !== 10'd0) $display("FAIL reset_fill got %0d want 0", w_fill); else n_pass++;
    n_checks++; if (w_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", w_empty); else n_pass++;
    n_checks++; if (p_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", p_ovf); else n_pass++;
    n_checks++; if (p_m_valid !== 1'b0) $display("FAIL reset_p_m_valid got %b want 0", p_m_valid); else n_pass++;
    rstn = 1'b1;
    tick();
    n_checks++; if (w_s_ready !== 1'b1) $display("FAIL post_reset_s_ready got %b want 1", w_s_ready); else n_pass++;
  endtask

  task automatic test_word_stream();
    logic [8:0] exp_q[$];
    logic [8:0] seen, exp;
    logic took;
    int got = 0;
    w_m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      w_s_valid = (c < 5);
      w_s_data  = 8'(c + 1);
      if (w_s_valid && w_s_ready) exp_q.push_back({1'b0, w_s_data});
      took = w_m_valid && w_m_ready;
      seen = {w_m_last, w_m_data};
      if (took) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL word_order unexpected word got %h", seen);
        else begin
          exp = exp_q.pop_front();
          if (seen !== exp) $display("FAIL word_order got %h want %h", seen, exp); else n_pass++;
        end
      end
      tick();
      if (c == 0) begin
        n_checks++; if (w_m_valid !== 1'b0) $display("FAIL word_latency_early got %b want 0", w_m_valid); else n_pass++;
      end
      if (c == 1) begin
        n_checks++;
        if (w_m_valid !== 1'b1 || w_m_data !== 8'h01) $display("FAIL word_first_out got v=%b d=%h want v=1 d=01", w_m_valid, w_m_data);
        else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if (w_m_valid !== 1'b1 || w_m_data !== 8'h05) $display("FAIL word_back_to_back got v=%b d=%h want v=1 d=05", w_m_valid, w_m_data);
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (w_m_valid !== 1'b0) $display("FAIL word_valid_fall got %b want 0", w_m_valid); else n_pass++;
      end
    end
    w_s_valid = 1'b0;
    n_checks++; if (got != 5 || exp_q.size() != 0) $display("FAIL word_count got %0d left %0d want 5 left 0", got, exp_q.size()); else n_pass++;
  endtask

  task automatic test_fill_full();
    logic [8:0] exp_q[$];
    logic [8:0] seen, exp;
    logic took;
    int acc = 0;
    w_m_ready = 1'b0;
    w_afth = 10'd500;
    w_aeth = 10'd4;
    w_s_valid = 1'b1;
    for (int c = 0; c < 530; c++) begin
      w_s_data = 8'(acc);
      if (w_s_ready) begin
        exp_q.push_back({1'b0, 8'(acc)});
        acc++;
      end
      tick();
      if (w_fill == 10'd4) begin
        n_checks++; if (w_aempty !== 1'b1) $display("FAIL aempty_at_4 got %b want 1", w_aempty); else n_pass++;
      end
      if (w_fill == 10'd5) begin
        n_checks++; if (w_aempty !== 1'b0) $display("FAIL aempty_at_5 got %b want 0", w_aempty); else n_pass++;
      end
      if (w_fill == 10'd499) begin
        n_checks++; if (w_afull !== 1'b0) $display("FAIL afull_at_499 got %b want 0", w_afull); else n_pass++;
      end
      if (w_fill == 10'd500) begin
        n_checks++; if (w_afull !== 1'b1) $display("FAIL afull_at_500 got %b want 1", w_afull); else n_pass++;
      end
    end
    n_checks++; if (acc != 513) $display("FAIL full_accept_count got %0d want 513", acc); else n_pass++;
    n_checks++; if (w_fill !== 10'd512) $display("FAIL full_fill got %0d want 512", w_fill); else n_pass++;
    n_checks++; if (w_full !== 1'b1) $display("FAIL full_flag got %b want 1", w_full); else n_pass++;
    n_checks++; if (w_s_ready !== 1'b0) $display("FAIL full_s_ready got %b want 0", w_s_ready); else n_pass++;
    w_afth = 10'd513;
    #1;
    n_checks++; if (w_afull !== 1'b0) $display("FAIL afull_runtime_thresh got %b want 0", w_afull); else n_pass++;
    w_afth = 10'd500;
    // Read and write requested together at full: write refused, read frees a slot.
    w_m_ready = 1'b1;
    w_s_data  = 8'(acc);
    took = w_m_valid && w_m_ready;
    seen = {w_m_last, w_m_data};
    n_checks++;
    if (!took || exp_q.size() == 0) $display("FAIL full_read_avail got v=%b want 1", w_m_valid);
    else begin
      exp = exp_q.pop_front();
      if (seen !== exp) $display("FAIL full_read_data got %h want %h", seen, exp); else n_pass++;
    end
    tick();
    n_checks++; if (w_fill !== 10'd511 || w_s_ready !== 1'b1) $display("FAIL full_rw_slot got fill=%0d rdy=%b want 511 1", w_fill, w_s_ready); else n_pass++;
    for (int c = 0; c < 2000 && (acc < 560 || exp_q.size() > 0); c++) begin
      w_s_valid = (acc < 560);
      w_s_data  = 8'(acc);
      w_m_ready = ($urandom_range(0, 3) != 0);
      if (w_s_valid && w_s_ready) begin
        exp_q.push_back({1'b0, 8'(acc)});
        acc++;
      end
      took = w_m_valid && w_m_ready;
      seen = {w_m_last, w_m_data};
      if (took) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL drain_order unexpected word got %h", seen);
        else begin
          exp = exp_q.pop_front();
          if (seen !== exp) $display("FAIL drain_order got %h want %h", seen, exp); else n_pass++;
        end
      end
      tick();
    end
    w_s_valid = 1'b0;
    w_m_ready = 1'b1;
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_timeout left %0d want 0", exp_q.size()); else n_pass++;
    tick();
    n_checks++; if (w_empty !== 1'b1 || w_m_valid !== 1'b0) $display("FAIL drain_empty got e=%b v=%b want 1 0", w_empty, w_m_valid); else n_pass++;
  endtask

  task automatic test_pkt_commit();
    logic [8:0] exp_q[$];
    logic [8:0] seen, exp;
    logic took;
    int got = 0;
    p_m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      p_s_valid = (c < 4);
      p_s_data  = 8'(8'hA1 + c);
      p_s_last  = (c == 3);
      if (p_s_valid && p_s_ready) exp_q.push_back({p_s_last, p_s_data});
      took = p_m_valid && p_m_ready;
      seen = {p_m_last, p_m_data};
      if (took) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL pkt_order unexpected word got %h", seen);
        else begin
          exp = exp_q.pop_front();
          if (seen !== exp) $display("FAIL pkt_order got %h want %h", seen, exp); else n_pass++;
        end
      end
      tick();
      if (c <= 3) begin
        n_checks++; if (p_m_valid !== 1'b0) $display("FAIL pkt_hold_c%0d got %b want 0", c, p_m_valid); else n_pass++;
      end
      if (c == 3) begin
        n_checks++; if (p_fill !== 4'd4) $display("FAIL pkt_fill got %0d want 4", p_fill); else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (p_m_valid !== 1'b1 || p_m_data !== 8'hA1) $display("FAIL pkt_first_out got v=%b d=%h want 1 a1", p_m_valid, p_m_data);
        else n_pass++;
      end
    end
    p_s_valid = 1'b0;
    p_s_last  = 1'b0;
    n_checks++; if (got != 4 || exp_q.size() != 0) $display("FAIL pkt_count got %0d left %0d want 4 0", got, exp_q.size()); else n_pass++;
  endtask

  task automatic test_pkt_drop();
    logic [8:0] exp_q[$];
    logic [8:0] seen, exp;
    logic took;
    int got = 0;
    p_m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      p_s_valid = (c < 4);
      p_s_data  = 8'(8'hB1 + c);
      p_s_drop  = (c == 3);
      tick();
      if (c == 2) begin
        n_checks++; if (p_fill !== 4'd3) $display("FAIL drop_prefill got %0d want 3", p_fill); else n_pass++;
      end
      if (c == 3) begin
        n_checks++; if (p_fill !== 4'd0) $display("FAIL drop_fill got %0d want 0", p_fill); else n_pass++;
      end
      n_checks++; if (p_m_valid !== 1'b0) $display("FAIL drop_no_output c%0d got %b want 0", c, p_m_valid); else n_pass++;
    end
    p_s_drop = 1'b0;
    for (int c = 0; c < 10; c++) begin
      p_s_valid = (c < 3);
      p_s_data  = 8'(8'hC1 + c);
      p_s_last  = (c == 2);
      if (p_s_valid && p_s_ready) exp_q.push_back({p_s_last, p_s_data});
      took = p_m_valid && p_m_ready;
      seen = {p_m_last, p_m_data};
      if (took) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL after_drop unexpected word got %h", seen);
        else begin
          exp = exp_q.pop_front();
          if (seen !== exp) $display("FAIL after_drop got %h want %h", seen, exp); else n_pass++;
        end
      end
      tick();
    end
    p_s_valid = 1'b0;
    p_s_last  = 1'b0;
    n_checks++; if (got != 3 || exp_q.size() != 0) $display("FAIL after_drop_count got %0d left %0d want 3 0", got, exp_q.size()); else n_pass++;
  endtask

  task automatic test_pkt_ovf();
    logic [8:0] exp_q[$];
    logic [8:0] seen, exp;
    logic took;
    logic ovf_seen = 1'b0;
    int acc = 0;
    int got = 0;
    p_m_ready = 1'b0;
    for (int c = 0; c < 40 && acc < 12; c++) begin
      p_s_valid = 1'b1;
      p_s_data  = 8'(8'h30 + acc);
      p_s_last  = (acc == 11);
      if (p_s_ready) acc++;
      tick();
      if (!ovf_seen && p_ovf === 1'b1) begin
        ovf_seen = 1'b1;
        n_checks++; if (p_fill !== 4'd0) $display("FAIL ovf_fill got %0d want 0", p_fill); else n_pass++;
        n_checks++; if (acc != 8) $display("FAIL ovf_at_beat got %0d want 8", acc); else n_pass++;
      end
      if (!ovf_seen && acc == 8) begin
        n_checks++;
        if (p_fill !== 4'd8 || p_full !== 1'b1 || p_s_ready !== 1'b0)
          $display("FAIL ovf_prefull got fill=%0d full=%b rdy=%b want 8 1 0", p_fill, p_full, p_s_ready);
        else n_pass++;
      end
    end
    p_s_valid = 1'b0;
    p_s_last  = 1'b0;
    n_checks++; if (acc != 12) $display("FAIL ovf_absorb got %0d want 12", acc); else n_pass++;
    tick();
    n_checks++;
    if (p_ovf !== 1'b1 || p_fill !== 4'd0 || p_m_valid !== 1'b0)
      $display("FAIL ovf_sticky got ovf=%b fill=%0d v=%b want 1 0 0", p_ovf, p_fill, p_m_valid);
    else n_pass++;
    p_clr = 1'b1;
    tick();
    p_clr = 1'b0;
    n_checks++; if (p_ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", p_ovf); else n_pass++;
    p_m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      p_s_valid = (c < 2);
      p_s_data  = 8'(8'hD1 + c);
      p_s_last  = (c == 1);
      if (p_s_valid && p_s_ready) exp_q.push_back({p_s_last, p_s_data});
      took = p_m_valid && p_m_ready;
      seen = {p_m_last, p_m_data};
      if (took) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL after_ovf unexpected word got %h", seen);
        else begin
          exp = exp_q.pop_front();
          if (seen !== exp) $display("FAIL after_ovf got %h want %h", seen, exp); else n_pass++;
        end
      end
      tick();
    end
    p_s_valid = 1'b0;
    p_s_last  = 1'b0;
    n_checks++; if (got != 2) $display("FAIL after_ovf_count got %0d want 2", got); else n_pass++;
  endtask

  task automatic test_flush_reset();
    w_m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      w_s_valid = 1'b1;
      w_s_data  = 8'(8'h50 + c);
      tick();
    end
    w_s_valid = 1'b0;
    tick();
    n_checks++; if (w_m_valid !== 1'b1 || w_fill !== 10'd4) $display("FAIL preflush got v=%b fill=%0d want 1 4", w_m_valid, w_fill); else n_pass++;
    w_flush   = 1'b1;
    w_s_valid = 1'b1;
    w_s_data  = 8'hEE;
    w_m_ready = 1'b1;
    tick();
    w_flush   = 1'b0;
    w_s_valid = 1'b0;
    n_checks++; if (w_m_valid !== 1'b0 || w_fill !== 10'd0) $display("FAIL flush got v=%b fill=%0d want 0 0", w_m_valid, w_fill); else n_pass++;
    tick();
    n_checks++; if (w_m_valid !== 1'b0 || w_empty !== 1'b1) $display("FAIL flush_write_ignored got v=%b e=%b want 0 1", w_m_valid, w_empty); else n_pass++;
    w_m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      w_s_valid = 1'b1;
      w_s_data  = 8'(8'h60 + c);
      tick();
    end
    w_s_valid = 1'b0;
    tick();
    rstn      = 1'b0;
    w_s_valid = 1'b1;
    #1;
    n_checks++; if (w_s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", w_s_ready); else n_pass++;
    tick();
    rstn      = 1'b1;
    w_s_valid = 1'b0;
    n_checks++; if (w_m_valid !== 1'b0 || w_fill !== 10'd0) $display("FAIL midrst got v=%b fill=%0d want 0 0", w_m_valid, w_fill); else n_pass++;
    tick();
    n_checks++; if (w_m_valid !== 1'b0) $display("FAIL midrst_stale got %b want 0", w_m_valid); else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [8:0] exp_q[$];
    logic [8:0] seen, exp;
    logic took;
    int sent = 0;
    for (int c = 0; c < 3000 && (sent < 300 || exp_q.size() > 0); c++) begin
      w_s_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
      w_s_data  = 8'($urandom);
      w_m_ready = ($urandom_range(0, 1) == 1);
      if (w_s_valid && w_s_ready) begin
        exp_q.push_back({1'b0, w_s_data});
        sent++;
      end
      took = w_m_valid && w_m_ready;
      seen = {w_m_last, w_m_data};
      if (took) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_order unexpected word got %h", seen);
        else begin
          exp = exp_q.pop_front();
          if (seen !== exp) $display("FAIL rand_order got %h want %h", seen, exp); else n_pass++;
        end
      end
      tick();
    end
    w_s_valid = 1'b0;
    n_checks++; if (sent != 300 || exp_q.size() != 0) $display("FAIL rand_timeout sent %0d left %0d want 300 0", sent, exp_q.size()); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0;
    w_flush = 1'b0; w_s_valid = 1'b0; w_s_data = '0; w_s_last = 1'b0; w_s_drop = 1'b0;
    w_m_ready = 1'b0; w_clr = 1'b0; w_afth = 10'd500; w_aeth = 10'd4;
    p_flush = 1'b0; p_s_valid = 1'b0; p_s_data = '0; p_s_last = 1'b0; p_s_drop = 1'b0;
    p_m_ready = 1'b0; p_clr = 1'b0; p_afth = 4'd6; p_aeth = 4'd1;
    test_reset();
    test_word_stream();
    test_fill_full();
    test_pkt_commit();
    test_pkt_drop();
    test_pkt_ovf();
    test_flush_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
